// File: rtl/parking_pkg.sv
// Shared definitions for the car-park entrance gate controller.
//   gate_state_t   : lane controller states
//   SEG_*          : active-low 7-segment glyphs, bit order {g,f,e,d,c,b,a}
//   state_digits() : two-digit display text for a state, {left, right}
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PASS,
        WRONG_PASS,
        RIGHT_PASS,
        STOP,
        LOCKOUT
    } gate_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_N   = 7'h2B;
    localparam logic [6:0] SEG_G   = 7'h02;
    localparam logic [6:0] SEG_O   = 7'h40;
    localparam logic [6:0] SEG_S   = 7'h12;
    localparam logic [6:0] SEG_P   = 7'h0C;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_U   = 7'h41;
    localparam logic [6:0] SEG_L   = 7'h47;

    function automatic logic [13:0] state_digits(input gate_state_t s, input logic full);
        case (s)
            IDLE:       return full ? {SEG_F, SEG_U} : {SEG_OFF, SEG_OFF};
            WAIT_PASS:  return {SEG_E, SEG_N};
            WRONG_PASS: return {SEG_E, SEG_E};
            RIGHT_PASS: return {SEG_G, SEG_O};
            STOP:       return {SEG_S, SEG_P};
            LOCKOUT:    return {SEG_L, SEG_O};
            default:    return {SEG_OFF, SEG_OFF};
        endcase
    endfunction

endpackage

// File: rtl/parking_occ_counter.sv
// Saturating bay-occupancy counter.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : a car entered this cycle
//   dec        : a car departed this cycle
//   count      : occupied bays, held within 0..CAPACITY
//   full       : count == CAPACITY
//   full_next  : value full takes after the coming edge
module parking_occ_counter #(
    parameter int CAPACITY = 8,
    localparam int OW = $clog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [OW-1:0] count,
    output logic          full,
    output logic          full_next
);

    localparam logic [OW-1:0] CAP_V = OW'(CAPACITY);

    logic [OW-1:0] count_next;

    // Simultaneous inc and dec cancel, so saturation only applies to a lone step.
    always_comb begin
        count_next = count;
        if (inc && !dec && count != CAP_V) begin
            count_next = count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign full      = (count == CAP_V);
    assign full_next = (count_next == CAP_V);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry-lane gate controller: password entry with timeout, retry limit and
// timed lockout, tailgate stop, bay occupancy with full-lot refusal.
//   clk, reset               : clock, asynchronous active-high reset
//   sensor_entrance          : car waiting at the entry sensor (level)
//   sensor_exit              : car past the gate sensor (level)
//   car_depart               : one-cycle pulse, a car left the lot
//   pass_valid, pass_code    : keypad strobe and entered code
//   gate_open                : gate actuator command
//   green_led, red_led       : status LEDs
//   hex_1, hex_2             : left/right digits, active-low {g,f,e,d,c,b,a}
//   occupancy, lot_full      : occupied bays, lot at capacity
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int              CAPACITY    = 8,
    parameter int              PW_W        = 4,
    parameter logic [PW_W-1:0] PASSCODE    = 4'h6,
    parameter int              WAIT_CYCLES = 16,
    parameter int              MAX_TRIES   = 3,
    parameter int              LOCK_CYCLES = 64,
    parameter int              BLINK_DIV   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sensor_entrance,
    input  logic                          sensor_exit,
    input  logic                          car_depart,
    input  logic                          pass_valid,
    input  logic [PW_W-1:0]               pass_code,
    output logic                          gate_open,
    output logic                          green_led,
    output logic                          red_led,
    output logic [6:0]                    hex_1,
    output logic [6:0]                    hex_2,
    output logic [$clog2(CAPACITY+1)-1:0] occupancy,
    output logic                          lot_full
);

    localparam int T_MAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int TRW   = $clog2(MAX_TRIES + 1);
    localparam int BW    = $clog2(BLINK_DIV + 1);

    localparam logic [TW-1:0]  WAIT_LAST  = TW'(WAIT_CYCLES - 1);
    localparam logic [TW-1:0]  LOCK_LAST  = TW'(LOCK_CYCLES - 1);
    localparam logic [TRW-1:0] TRIES_MAX  = TRW'(MAX_TRIES);
    localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_DIV - 1);

    gate_state_t    state, next_state;
    logic [TW-1:0]  timer, timer_next;
    logic [TRW-1:0] tries, tries_next;
    logic [BW-1:0]  bcnt, bcnt_next;
    logic           blink, blink_next;
    logic           code_ok, code_bad, entry_evt, full_next;
    logic           gate_next, green_next, red_next;

    assign code_ok  = pass_valid && (pass_code == PASSCODE);
    assign code_bad = pass_valid && (pass_code != PASSCODE);

    parking_occ_counter #(.CAPACITY(CAPACITY)) u_occ (
        .clk       (clk),
        .reset     (reset),
        .inc       (entry_evt),
        .dec       (car_depart),
        .count     (occupancy),
        .full      (lot_full),
        .full_next (full_next)
    );

    always_comb begin
        next_state = state;
        tries_next = tries;
        entry_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (sensor_entrance && !lot_full) next_state = WAIT_PASS;
            end
            WAIT_PASS: begin
                // A strobe on the expiry cycle still counts.
                if (code_ok) begin
                    next_state = RIGHT_PASS;
                end else if (code_bad) begin
                    next_state = WRONG_PASS;
                    tries_next = tries + 1'b1;
                end else if (timer == WAIT_LAST) begin
                    next_state = IDLE;
                end
            end
            WRONG_PASS: begin
                if (tries == TRIES_MAX) begin
                    next_state = LOCKOUT;
                end else if (code_ok) begin
                    next_state = RIGHT_PASS;
                end else if (code_bad) begin
                    tries_next = tries + 1'b1;
                end
            end
            RIGHT_PASS: begin
                if (sensor_entrance && sensor_exit) begin
                    next_state = STOP;
                end else if (sensor_exit) begin
                    next_state = IDLE;
                    entry_evt  = 1'b1;
                end
            end
            STOP: begin
                if (code_ok) next_state = RIGHT_PASS;
            end
            LOCKOUT: begin
                if (timer == LOCK_LAST) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (state == IDLE || state == RIGHT_PASS) tries_next = '0;
    end

    // Timer and blink phase both restart whenever the state changes.
    always_comb begin
        timer_next = '0;
        bcnt_next  = '0;
        blink_next = 1'b0;
        if (next_state == state) begin
            if (state == WAIT_PASS || state == LOCKOUT) timer_next = timer + 1'b1;
            if (state inside {WRONG_PASS, RIGHT_PASS, STOP, LOCKOUT}) begin
                if (bcnt == BLINK_LAST) begin
                    blink_next = ~blink;
                end else begin
                    bcnt_next  = bcnt + 1'b1;
                    blink_next = blink;
                end
            end
        end
    end

    always_comb begin
        gate_next  = 1'b0;
        green_next = 1'b0;
        red_next   = 1'b0;
        case (next_state)
            WAIT_PASS, LOCKOUT: red_next = 1'b1;
            WRONG_PASS, STOP:   red_next = blink_next;
            RIGHT_PASS: begin
                gate_next  = 1'b1;
                green_next = blink_next;
            end
            default: ;
        endcase
    end

    // Outputs are decoded from next-cycle values so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            tries     <= '0;
            bcnt      <= '0;
            blink     <= 1'b0;
            gate_open <= 1'b0;
            green_led <= 1'b0;
            red_led   <= 1'b0;
            hex_1     <= SEG_OFF;
            hex_2     <= SEG_OFF;
        end else begin
            state          <= next_state;
            timer          <= timer_next;
            tries          <= tries_next;
            bcnt           <= bcnt_next;
            blink          <= blink_next;
            gate_open      <= gate_next;
            green_led      <= green_next;
            red_led        <= red_next;
            {hex_1, hex_2} <= state_digits(next_state, full_next);
        end
    end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Parametrised gate controller for the car-park entrance. It runs one entry lane through password entry, tailgate detection and the gate pass, and adds features the first-generation controller lacked: a bay occupancy count with a full-lot refusal, a password timeout, a retry limit with timed lockout, and a configurable code width. It sits between the lane sensors and keypad decoder on one side and the gate actuator, status LEDs and two 7-segment digits on the other.

## Interface
Parameters:
- CAPACITY, 8, number of bays; occupancy saturates here
- PW_W, 4, password width in bits
- PASSCODE, 4'h6, accepted code (PW_W bits)
- WAIT_CYCLES, 16, cycles allowed in WAIT_PASS before timeout (≥1)
- MAX_TRIES, 3, wrong codes that trigger lockout (≥1)
- LOCK_CYCLES, 64, lockout duration in cycles (≥1)
- BLINK_DIV, 2, cycles per LED blink half-period (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- sensor_entrance  in  1  car present at entry sensor (level)
- sensor_exit  in  1  car past gate sensor (level)
- car_depart  in  1  one-cycle pulse, a car has left the lot
- pass_valid  in  1  one-cycle strobe, pass_code is valid
- pass_code  in  PW_W  entered code
- gate_open  out  1  gate actuator command
- green_led  out  1  green status LED
- red_led  out  1  red status LED
- hex_1  out  7  left digit, active-low, {g,f,e,d,c,b,a}
- hex_2  out  7  right digit, active-low
- occupancy  out  $clog2(CAPACITY+1)  occupied bays
- lot_full  out  1  occupancy == CAPACITY

## Operation
The FSM has six states: IDLE, WAIT_PASS, WRONG_PASS, RIGHT_PASS, STOP and LOCKOUT.

State transitions (next-state priority is top to bottom within each state):
- IDLE
  - sensor_entrance & !lot_full → WAIT_PASS.
  - sensor_entrance & lot_full → stay; the display shows "FU".
- WAIT_PASS
  - pass_valid with the correct code → RIGHT_PASS.
  - pass_valid with a wrong code → WRONG_PASS, tries += 1.
  - No strobe after WAIT_CYCLES cycles in the state → IDLE (timeout).
- WRONG_PASS
  - If tries == MAX_TRIES on entry → LOCKOUT.
  - Correct pass_valid → RIGHT_PASS.
  - Wrong pass_valid → tries += 1; stay.
- RIGHT_PASS
  - sensor_entrance & sensor_exit → STOP (tailgate).
  - sensor_exit alone → IDLE, with an entry event.
- STOP
  - Correct pass_valid → RIGHT_PASS.
  - Any other input, including a wrong code → stay.
- LOCKOUT
  - Stays exactly LOCK_CYCLES cycles, then → IDLE. All inputs except car_depart are ignored.

Counters and LEDs:
- tries clears in IDLE and RIGHT_PASS.
- The wait/lock counter clears on every state change.
- Occupancy:
  - An entry event gives +1.
  - car_depart gives −1.
  - Both in the same cycle give net 0.
  - The count saturates at 0 and at CAPACITY and never wraps.
  - car_depart is honoured in every state.
- Blink register:
  - Toggles every BLINK_DIV cycles while in WRONG_PASS, RIGHT_PASS, STOP or LOCKOUT.
  - Resets to 0 on every state change.

Outputs are a Moore decode of the state:
- IDLE: LEDs 0/0; digits off, or "FU" when lot_full.
- WAIT_PASS: red = 1; digits "En".
- WRONG_PASS: red = blink; digits "EE".
- RIGHT_PASS: green = blink; gate_open = 1; digits "GO".
- STOP: red = blink; digits "SP".
- LOCKOUT: red = 1; digits "LO".
- gate_open is 1 only in RIGHT_PASS.

## Timing
- Reset values:
  - state = IDLE; all counters = 0.
  - gate_open = 0; green_led = 0; red_led = 0.
  - hex_1 = hex_2 = 7'h7F; occupancy = 0; lot_full = 0.
- State, counters and occupancy are registered on the rising edge of clk.
- Outputs are registered from next_state: they change in the same cycle the state register changes, so input-to-output latency is 1 cycle.
- A pass_valid strobe is sampled once. A strobe in the same cycle as a timeout expiry wins over the timeout.
- An entry event and car_depart in the same cycle net to 0, with lot_full recomputed from the result.
- Reset asserted mid-operation aborts immediately to the reset values; occupancy is lost.

## Structure
- Package parking_pkg holds:
  - the state enum;
  - 7-segment constants: SEG_OFF = 7F, E = 06, n = 2B, G = 02, O = 40, S = 12, P = 0C, F = 0E, U = 41, L = 47.
- Sub-module parking_occ_counter (saturating up/down counter, parameter CAPACITY) is instantiated once.
- The FSM, timers and output decode live in parking_gate_ctrl.

## Test plan
- Correct entry: occupancy 0, entrance, pass_valid code 6 on the 3rd cycle → RIGHT_PASS, gate_open = 1, "GO"; then exit → IDLE, occupancy = 1.
- Lockout: codes 1, 2, 3 → LOCKOUT, "LO", red = 1 for exactly 64 cycles → IDLE; a correct code during lockout is ignored.
- Timeout: entrance, no strobe for 16 cycles → IDLE, red = 0, digits off.
- Tailgate: in RIGHT_PASS drive entrance = exit = 1 → STOP, "SP", red blinking at period 4; a wrong code keeps STOP; code 6 → RIGHT_PASS.
- Full lot and saturation:
  - 8 entries → lot_full = 1; a further entrance stays IDLE with "FU".
  - An entry event plus car_depart in the same cycle keeps occupancy = 8.
  - car_depart at occupancy 0 stays 0.
- Reset mid-RIGHT_PASS: all outputs return to their reset values, with no glitch on gate_open after reset.
